// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter width helper.
package mdu_iter_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } mdu_state_e;

    // Counter must hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int mdu_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute-stage control and the multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             MDU_start;
    logic [2:0]       MDU_op;
    logic [WIDTH-1:0] MDU_operand_1;
    logic [WIDTH-1:0] MDU_operand_2;
    logic             MDU_busy;
    logic             MDU_done;
    logic [WIDTH-1:0] MDU_hi;
    logic [WIDTH-1:0] MDU_lo;
    logic             MDU_div_zero;
    logic             MDU_illegal;

    modport master (
        output MDU_start, MDU_op, MDU_operand_1, MDU_operand_2,
        input  MDU_busy, MDU_done, MDU_hi, MDU_lo, MDU_div_zero, MDU_illegal
    );

    modport slave (
        input  MDU_start, MDU_op, MDU_operand_1, MDU_operand_2,
        output MDU_busy, MDU_done, MDU_hi, MDU_lo, MDU_div_zero, MDU_illegal
    );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// The divide half exists only when MDU_DIV_EN is defined.
module mdu_step
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MDU_DIV_EN
    input  logic               i_div,
`endif
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_acc;

    // Multiply: {partial product, remaining multiplier bits}, LSB selects the add.
    assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    assign w_mul_acc = {w_sum, i_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_acc;

    // Divide: {remainder, dividend/quotient}; borrow out of w_trial means restore.
    assign w_trial   = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_operand};
    assign w_div_acc = w_trial[WIDTH] ? {i_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    assign o_acc     = i_div ? w_div_acc : w_mul_acc;
`else
    assign o_acc     = w_mul_acc;
`endif

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO; FSM, counter, sign handling and HI/LO live here.
// Divide ops and MDU_div_zero are compiled in only when MDU_DIV_EN is defined.
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops complete here
//   RUN   | one radix-2 step per cycle, WIDTH cycles
//   FIX   | sign correction and HI/LO write
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      SYS_clk,
    input  logic      SYS_reset,
    mdu_iter_if.slave mdu
);
    localparam int CNT_W = mdu_cnt_width(WIDTH);

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_neg_res;
    logic               r_busy;
    logic               r_done;
    logic               r_illegal;
`ifdef MDU_DIV_EN
    logic               r_is_div;
    logic               r_neg_rem;
    logic               r_div_zero;
`endif

    logic               w_signed;
    logic               w_neg_1;
    logic               w_neg_2;
    logic [WIDTH-1:0]   w_mag_1;
    logic [WIDTH-1:0]   w_mag_2;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed = (mdu.MDU_op == MDU_OP_MULT) || (mdu.MDU_op == MDU_OP_DIV);
    assign w_neg_1  = w_signed & mdu.MDU_operand_1[WIDTH-1];
    assign w_neg_2  = w_signed & mdu.MDU_operand_2[WIDTH-1];
    assign w_mag_1  = w_neg_1 ? -mdu.MDU_operand_1 : mdu.MDU_operand_1;
    assign w_mag_2  = w_neg_2 ? -mdu.MDU_operand_2 : mdu.MDU_operand_2;
    assign w_prod   = r_neg_res ? -r_acc : r_acc;

    mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
        .i_div     (r_is_div),
`endif
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .o_acc     (w_step_acc)
    );

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg_res  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef MDU_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mdu.MDU_start) begin
`ifdef MDU_DIV_EN
                        r_div_zero <= 1'b0;
`endif
                        case (mdu.MDU_op)
                            MDU_OP_MULT, MDU_OP_MULTU: begin
                                r_acc     <= {{WIDTH{1'b0}}, w_mag_2};
                                r_opnd    <= w_mag_1;
                                r_neg_res <= w_neg_1 ^ w_neg_2;
`ifdef MDU_DIV_EN
                                r_is_div  <= 1'b0;
`endif
                                r_cnt     <= CNT_W'(WIDTH);
                                r_busy    <= 1'b1;
                                r_state   <= ST_RUN;
                            end
`ifdef MDU_DIV_EN
                            MDU_OP_DIV, MDU_OP_DIVU: begin
                                if (mdu.MDU_operand_2 == '0) begin
                                    r_hi       <= mdu.MDU_operand_1;
                                    r_lo       <= '1;
                                    r_div_zero <= 1'b1;
                                    r_done     <= 1'b1;
                                end else begin
                                    r_acc     <= {{WIDTH{1'b0}}, w_mag_1};
                                    r_opnd    <= w_mag_2;
                                    r_neg_res <= w_neg_1 ^ w_neg_2;
                                    r_neg_rem <= w_neg_1;
                                    r_is_div  <= 1'b1;
                                    r_cnt     <= CNT_W'(WIDTH);
                                    r_busy    <= 1'b1;
                                    r_state   <= ST_RUN;
                                end
                            end
`endif
                            MDU_OP_MTHI: begin
                                r_hi   <= mdu.MDU_operand_1;
                                r_done <= 1'b1;
                            end
                            MDU_OP_MTLO: begin
                                r_lo   <= mdu.MDU_operand_1;
                                r_done <= 1'b1;
                            end
                            default: r_illegal <= 1'b1;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
`ifdef MDU_DIV_EN
                    if (r_is_div) begin
                        r_lo <= r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                        r_hi <= r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                    end else
`endif
                    begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mdu.MDU_busy     = r_busy;
    assign mdu.MDU_done     = r_done;
    assign mdu.MDU_hi       = r_hi;
    assign mdu.MDU_lo       = r_lo;
    assign mdu.MDU_illegal  = r_illegal;
`ifdef MDU_DIV_EN
    assign mdu.MDU_div_zero = r_div_zero;
`else
    assign mdu.MDU_div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized ops against an
// arithmetic reference model of HI/LO; divide cases depend on MDU_DIV_EN.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .SYS_clk   (clk),
        .SYS_reset (rst),
        .mdu       (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 = iterative, 1 = single-cycle done, 2 = illegal
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int kind, output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dz);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        hi   = m_hi;
        lo   = m_lo;
        dz   = 1'b0;
        kind = 2;
        case (op)
            MDU_OP_MULT: begin
                p = 64'(sa * sb);
                {hi, lo} = p;
                kind = 0;
            end
            MDU_OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {hi, lo} = p;
                kind = 0;
            end
`ifdef MDU_DIV_EN
            MDU_OP_DIV, MDU_OP_DIVU: begin
                if (b == '0) begin
                    kind = 1; hi = a; lo = '1; dz = 1'b1;
                end else if (op == MDU_OP_DIV) begin
                    kind = 0; lo = W'(sa / sb); hi = W'(sa % sb);
                end else begin
                    kind = 0; lo = a / b; hi = a % b;
                end
            end
`endif
            MDU_OP_MTHI: begin kind = 1; hi = a; end
            MDU_OP_MTLO: begin kind = 1; lo = a; end
            default: kind = 2;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("quiet", 64'({bus.MDU_busy, bus.MDU_done, bus.MDU_illegal}), 64'd0);
            chk("hold", 64'({bus.MDU_hi, bus.MDU_lo, bus.MDU_div_zero}), 64'({m_hi, m_lo, m_dz}));
        end
    endtask

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int kind;
        int bad;
        logic [W-1:0] e_hi;
        logic [W-1:0] e_lo;
        logic e_dz;
        model(op, a, b, kind, e_hi, e_lo, e_dz);
        bus.MDU_start     = 1'b1;
        bus.MDU_op        = op;
        bus.MDU_operand_1 = a;
        bus.MDU_operand_2 = b;
        @(negedge clk);
        bus.MDU_start     = 1'b0;
        bus.MDU_op        = 3'($urandom);
        bus.MDU_operand_1 = $urandom;
        bus.MDU_operand_2 = $urandom;
        if (kind == 0) begin
            bad = 0;
            for (int k = 1; k <= W + 1; k++) begin
                if (bus.MDU_busy !== 1'b1 || bus.MDU_done !== 1'b0 || bus.MDU_illegal !== 1'b0 ||
                    bus.MDU_div_zero !== 1'b0 || bus.MDU_hi !== m_hi || bus.MDU_lo !== m_lo)
                    bad++;
                if (poke && k == 10) begin
                    bus.MDU_start     = 1'b1;
                    bus.MDU_op        = 3'($urandom_range(0, 7));
                    bus.MDU_operand_1 = $urandom;
                    bus.MDU_operand_2 = $urandom;
                end else begin
                    bus.MDU_start = 1'b0;
                end
                @(negedge clk);
            end
            chk("busy_window", 64'(bad), 64'd0);
            chk("done_cycle", 64'({bus.MDU_busy, bus.MDU_done, bus.MDU_illegal}), 64'b010);
        end else if (kind == 1) begin
            chk("single_done", 64'({bus.MDU_busy, bus.MDU_done, bus.MDU_illegal}), 64'b010);
        end else begin
            chk("illegal_pulse", 64'({bus.MDU_busy, bus.MDU_done, bus.MDU_illegal}), 64'b001);
        end
        chk("hi", 64'(bus.MDU_hi), 64'(e_hi));
        chk("lo", 64'(bus.MDU_lo), 64'(e_lo));
        chk("div_zero", 64'(bus.MDU_div_zero), 64'(e_dz));
        m_hi = e_hi;
        m_lo = e_lo;
        m_dz = e_dz;
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.MDU_start     = 1'b0;
        bus.MDU_op        = 3'd0;
        bus.MDU_operand_1 = '0;
        bus.MDU_operand_2 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_vals", 64'({bus.MDU_busy, bus.MDU_done, bus.MDU_illegal, bus.MDU_div_zero}), 64'd0);
        chk("reset_hilo", {bus.MDU_hi, bus.MDU_lo}, 64'd0);
        rst = 1'b0;
        idle(2);

        do_op(MDU_OP_MULT, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
        chk("mult_lit", {bus.MDU_hi, bus.MDU_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        idle(1);
        do_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
        chk("multu_lit", {bus.MDU_hi, bus.MDU_lo}, 64'h0000_0002_FFFF_FFFD);
        idle(1);

`ifdef MDU_DIV_EN
        do_op(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lit", {bus.MDU_hi, bus.MDU_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lit", {bus.MDU_hi, bus.MDU_lo}, 64'h0000_0000_8000_0000);
        idle(1);
        do_op(MDU_OP_DIVU, 32'd100, 32'd0, 1'b0);
        chk("divz_lit", {bus.MDU_hi, bus.MDU_lo}, 64'h0000_0064_FFFF_FFFF);
`else
        do_op(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(MDU_OP_DIVU, 32'd100, 32'd0, 1'b0);
`endif
        do_op(MDU_OP_MTLO, 32'd5, 32'd0, 1'b0);
        chk("mtlo_lit", 64'({bus.MDU_lo, bus.MDU_div_zero}), 64'({32'd5, 1'b0}));
        idle(1);

        // start while busy must be ignored
        do_op(MDU_OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        do_op(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0);
        idle(1);

        // reset mid-operation
        bus.MDU_start     = 1'b1;
`ifdef MDU_DIV_EN
        bus.MDU_op        = MDU_OP_DIVU;
`else
        bus.MDU_op        = MDU_OP_MULTU;
`endif
        bus.MDU_operand_1 = 32'h0BAD_F00D;
        bus.MDU_operand_2 = 32'd3;
        @(negedge clk);
        bus.MDU_start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctl", 64'({bus.MDU_busy, bus.MDU_done, bus.MDU_illegal, bus.MDU_div_zero}), 64'd0);
        chk("abort_hilo", {bus.MDU_hi, bus.MDU_lo}, 64'd0);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        idle(40);

        // reset and start in the same cycle: start dropped
        rst               = 1'b1;
        bus.MDU_start     = 1'b1;
        bus.MDU_op        = MDU_OP_MTHI;
        bus.MDU_operand_1 = 32'hCAFE_0001;
        @(negedge clk);
        chk("rst_wins", {bus.MDU_hi, 30'd0, bus.MDU_done, bus.MDU_busy}, 64'd0);
        rst           = 1'b0;
        bus.MDU_start = 1'b0;
        idle(2);

        do_op(MDU_OP_MULTU, 32'd6, 32'd7, 1'b0);
        chk("six_by_seven", 64'(bus.MDU_lo), 64'd42);
        idle(1);

        for (int t = 0; t < 60; t++) begin
            do_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the processor core. It sits beside the ALU in the execute stage and is fed from the register file read ports. A start/busy/done handshake lets the control unit stall while a multi-cycle operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 4
- SYS_clk  in  1  clock; all state updates on rising edge
- SYS_reset  in  1  synchronous, active-high reset
- MDU_start  in  1  request; accepted only when MDU_busy = 0
- MDU_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 illegal
- MDU_operand_1  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- MDU_operand_2  in  WIDTH  multiplier / divisor
- MDU_busy  out  1  operation in flight
- MDU_done  out  1  one-cycle pulse; HI/LO valid in the same cycle
- MDU_hi  out  WIDTH  HI register
- MDU_lo  out  WIDTH  LO register
- MDU_div_zero  out  1  last accepted divide had divisor 0; held until next accepted start
- MDU_illegal  out  1  one-cycle pulse on an illegal or compiled-out op

## Operation
- States: IDLE, RUN, FIX. Reset enters IDLE.
- IDLE + MDU_start:
  - Operands are latched on that edge; later operand changes have no effect.
  - Signed ops latch magnitudes and record the result signs.
  - MUL/DIV ops → RUN with iteration counter = WIDTH.
  - MTHI/MTLO: the target register is written on the accept edge, the other is unchanged. State stays IDLE. MDU_done pulses next cycle.
  - DIV/DIVU with divisor 0: state stays IDLE. HI = dividend, LO = all ones, MDU_div_zero = 1, MDU_done pulses next cycle.
  - Op 6–7: no register change. MDU_illegal pulses next cycle. No done.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, giving a WIDTH-bit quotient and remainder.
  - Counter decrements; when it reaches 1 the next state is FIX.
- FIX: apply sign correction.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - HI/LO are written. MDU_done pulses in the following cycle. → IDLE.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0, no flag.
- MDU_start while busy is ignored; it is not queued.
- HI/LO are only ever written by completing operations, MTHI/MTLO, the divide-by-zero path, or reset.

## Timing
- Reset values: MDU_busy 0, MDU_done 0, MDU_hi 0, MDU_lo 0, MDU_div_zero 0, MDU_illegal 0. Accumulators and counter are cleared.
- Cycle numbering: start accepted at edge 0.
- MUL/DIV:
  - MDU_busy is high in cycles 1..WIDTH+1.
  - HI/LO are updated at edge WIDTH+1.
  - MDU_done is high in cycle WIDTH+2 (34 for WIDTH=32), with MDU_busy = 0 in that cycle.
- Single-cycle paths (MTHI/MTLO, ÷0, illegal): response in cycle 1. MDU_busy never asserts.
- Back-to-back: a new start may be accepted in the MDU_done cycle.
- Reset mid-operation:
  - Takes effect at the next edge and aborts the operation.
  - All outputs take their reset values; no done pulse.
- Reset and start in the same cycle: reset wins and the start is dropped.

## Configuration
- MDU_DIV_EN defined: the divide datapath, the DIV/DIVU ops and MDU_div_zero are all present.
- MDU_DIV_EN undefined:
  - Ops 2–3 behave as illegal (MDU_illegal pulse, no register change).
  - The divide datapath is removed.
  - MDU_div_zero is tied to 0.

## Structure
- Shared package holds:
  - Op-code constants (MDU_OP_MULT … MDU_OP_MTLO).
  - The state enum (IDLE/RUN/FIX).
  - The counter width constant, $clog2(WIDTH+1).
- Sub-module mdu_step: the combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide), instantiated once.
- Top level owns the FSM, counter, sign bookkeeping and HI/LO.

## Test plan
1. MULT 0xFFFFFFFF × 0x00000003 → busy for cycles 1–33. Done in cycle 34 with HI=0xFFFFFFFF, LO=0xFFFFFFFD.
2. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFD.
3. DIV 0xFFFFFFF9 (−7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
4. DIVU 100 ÷ 0 → cycle 1: done=1, div_zero=1, HI=100, LO=0xFFFFFFFF. A following MTLO 5 clears div_zero and gives LO=5, HI unchanged.
5. Second MULT started at cycle 10 of a run → ignored, first result intact. Reset asserted at cycle 20 of a DIVU → cycle 21 all outputs 0, no done; a new MULTU 6×7 then yields LO=42.
6. Op 7, and DIV with MDU_DIV_EN undefined → MDU_illegal pulses in cycle 1, HI/LO unchanged, no done.
